mpadd_ctrl: RTL and testbench
=============================

Name: mpadd_ctrl

Overview:
Multi-precision add/subtract sequencer that time-shares a single 16-bit ripple-carry adder (rca16) across WORDS 16-bit limbs.
- Accepts full-width operands over a valid/ready handshake.
- Processes one limb per cycle, LSB first, chaining carry through a register.
- Returns the full-width result, carry and signed overflow over a second handshake.
- Sits between the ALU opcode decoder and the result writeback stage.

Parameters:
WORDS, 4, number of 16-bit limbs; operand width W = 16*WORDS; legal 2..16
IDX_W, $clog2(WORDS), limb index counter width (derived, not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/opcode valid
in_ready  output  1  controller can accept a new operation
op1  input  W  operand A
op2  input  W  operand B
sub  input  1  0 = A+B, 1 = A-B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  W  result
carry_out  output  1  add: carry out; sub: 1 = no borrow (A >= B unsigned)
overflow  output  1  signed two's-complement overflow

Behaviour:
- Clocking and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, carry_out=0, overflow=0, limb index=0, carry reg=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch op1, op2 (op2 latched as ~op2 when sub=1), and sub. Set carry reg=sub, index=0, go to RUN.
  - RUN: in_ready=0. Each cycle, feed limb[index] of A and B' plus carry reg to rca16. Write the limb sum into sum[16*index +: 16]. Carry reg <= rca16 carry_out. At index==WORDS-1: compute overflow = (A[W-1]==B'[W-1]) && (sum[W-1]!=A[W-1]); latch carry_out; go to DONE. Otherwise index+1.
  - DONE: out_valid=1. sum, carry_out and overflow are held stable until out_valid&&out_ready; then go to IDLE with index cleared.
- Latency: handshake in cycle 0; limbs processed in cycles 1..WORDS; out_valid first high in cycle WORDS+1. Throughput is one op per WORDS+2 cycles minimum.
- No bypass: in_ready is never 1 in the same cycle as out_valid, so there is no simultaneous accept/return.
- in_valid while busy is ignored; the requester must hold it until in_ready.
- Backpressure: out_ready low stalls indefinitely in DONE with outputs frozen.
- sum register bits for unprocessed limbs hold the previous operation's values during RUN. The consumer samples only while out_valid=1.
- Reset mid-RUN or mid-DONE: immediate return to reset values. The in-flight result is discarded and no out_valid pulse is produced.
- Arithmetic is modulo 2^W. Subtraction uses A + ~B + 1 via carry-in.

Optional Feature:
Macro MPADD_OPCOUNT_EN.
- Defined: adds output port op_count [15:0]. It increments on each out_valid&&out_ready, saturates at 0xFFFF, and resets to 0 on rst_n.
- Undefined: port and counter are absent; otherwise identical behaviour.

Decomposition:
- Package alu_pkg: typedef enum logic [1:0] {MP_IDLE, MP_RUN, MP_DONE} mp_state_t; localparam LIMB_W = 16.
- Sub-module: reuse the existing rca16 as the single limb datapath instance.
- No other sub-modules.

Test Plan:
1. WORDS=4, A=0x0000_0000_0000_FFFF, B=0x1, sub=0 -> sum=0x0000_0000_0001_0000, carry_out=0, overflow=0; out_valid exactly 5 cycles after the accept cycle.
2. A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, sub=0 -> sum=0, carry_out=1, overflow=0 (carry ripples through all 4 limbs).
3. A=0x0, B=0x1, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFF, carry_out=0 (borrow), overflow=0. Then A=0x8000_0000_0000_0000, B=0x1, sub=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, overflow=1.
4. A=0x7FFF_FFFF_FFFF_FFFF, B=0x1, sub=0 -> sum=0x8000_0000_0000_0000, overflow=1, carry_out=0.
5. Hold out_ready=0 for 6 cycles in DONE while driving in_valid=1 with new operands -> sum is stable, in_ready=0, and the new op is not accepted until the cycle after out_ready=1.
6. Assert rst_n=0 during the 2nd RUN cycle -> all outputs at reset values asynchronously. After release, a new op completes correctly and out_valid is never pulsed for the aborted op. With MPADD_OPCOUNT_EN, op_count=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types for the multi-precision add/subtract sequencer.
package alu_pkg;
    localparam int LIMB_W = 16;

    typedef enum logic [1:0] {MP_IDLE, MP_RUN, MP_DONE} mp_state_t;
endpackage

// File: rtl/rca16.sv
// 16-bit ripple-carry adder: one limb of the multi-precision datapath.
module rca16
    import alu_pkg::*;
(
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              ci,
    output logic [LIMB_W-1:0] s,
    output logic              co
);
    // Carry held in a block-local variable so the chain stays a clean ripple.
    always_comb begin : ripple
        logic c;
        c  = ci;
        s  = '0;
        for (int i = 0; i < LIMB_W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end
endmodule

// File: rtl/mpadd_ctrl.sv
// Multi-precision add/sub sequencer: one rca16 time-shared over WORDS limbs, LSB first.
// Optional MPADD_OPCOUNT_EN adds a saturating completed-operation counter (op_count).
module mpadd_ctrl
    import alu_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int W     = LIMB_W * WORDS,
    localparam int IDX_W = $clog2(WORDS)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         carry_out,
`ifdef MPADD_OPCOUNT_EN
    output logic [15:0]  op_count,
`endif
    output logic         overflow
);
    mp_state_t        state_q, state_d;
    logic [W-1:0]     a_q, b_q, sum_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q, carry_out_q, overflow_q;
    logic [LIMB_W-1:0] limb_s;
    logic             limb_co;
    logic             last;

    assign last = (idx_q == IDX_W'(WORDS - 1));

    rca16 u_rca (
        .a  (a_q[LIMB_W*idx_q +: LIMB_W]),
        .b  (b_q[LIMB_W*idx_q +: LIMB_W]),
        .ci (carry_q),
        .s  (limb_s),
        .co (limb_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= MP_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            MP_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = MP_RUN;
            end
            MP_RUN:  if (last) state_d = MP_DONE;
            MP_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = MP_IDLE;
            end
            default: state_d = MP_IDLE;
        endcase
    end

    // B is stored pre-inverted for subtraction; the +1 enters as carry-in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                MP_IDLE: if (in_valid) begin
                    a_q     <= op1;
                    b_q     <= sub ? ~op2 : op2;
                    carry_q <= sub;
                    idx_q   <= '0;
                end
                MP_RUN: begin
                    sum_q[LIMB_W*idx_q +: LIMB_W] <= limb_s;
                    carry_q <= limb_co;
                    if (last) begin
                        carry_out_q <= limb_co;
                        overflow_q  <= (a_q[W-1] == b_q[W-1]) && (limb_s[LIMB_W-1] != a_q[W-1]);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                MP_DONE: if (out_ready) idx_q <= '0;
                default: ;
            endcase
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

`ifdef MPADD_OPCOUNT_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                            op_count_q <= '0;
        else if (out_valid && out_ready && op_count_q != 16'hFFFF) op_count_q <= op_count_q + 16'd1;
    end

    assign op_count = op_count_q;
`endif
endmodule

// File: tb/tb_mpadd_ctrl.sv
// Randomized self-checking bench for mpadd_ctrl (WORDS=4) against an arithmetic reference model.
module tb_mpadd_ctrl;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;
`ifdef MPADD_OPCOUNT_EN
    logic [15:0]  op_count;
    int           exp_count = 0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_sum;
    logic         exp_c, exp_v;

    always #5 clk = ~clk;

    mpadd_ctrl #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
`ifdef MPADD_OPCOUNT_EN
        .op_count  (op_count),
`endif
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain W-bit arithmetic; signed overflow from operand/result signs.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W:0] t;
        if (!s) begin
            t       = {1'b0, a} + {1'b0, b};
            exp_sum = t[W-1:0];
            exp_c   = t[W];
            exp_v   = (a[W-1] == b[W-1]) && (exp_sum[W-1] != a[W-1]);
        end else begin
            exp_sum = a - b;
            exp_c   = (a >= b);
            exp_v   = (a[W-1] != b[W-1]) && (exp_sum[W-1] != a[W-1]);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        in_valid = 1'b1;
        op1 = a;
        op2 = b;
        sub = s;
        chk("in_ready_idle", W'(in_ready), W'(1));
        model(a, b, s);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble inputs to prove the operands were latched
        op1 = {$urandom, $urandom};
        op2 = {$urandom, $urandom};
        sub = 1'($urandom);
    endtask

    task automatic wait_done();
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 64);
        chk("latency", W'(lat), W'(WORDS + 1));
        chk("in_ready_done", W'(in_ready), W'(0));
        chk("sum", sum, exp_sum);
        chk("carry_out", W'(carry_out), W'(exp_c));
        chk("overflow", W'(overflow), W'(exp_v));
    endtask

    task automatic release_out(input int stall);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", W'(out_valid), W'(1));
            chk("stall_sum", sum, exp_sum);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
`ifdef MPADD_OPCOUNT_EN
        if (exp_count < 16'hFFFF) exp_count++;
`endif
        @(negedge clk);
        chk("post_valid", W'(out_valid), W'(0));
        chk("post_in_ready", W'(in_ready), W'(1));
`ifdef MPADD_OPCOUNT_EN
        chk("op_count", W'(op_count), W'(exp_count));
`endif
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int stall);
        issue(a, b, s);
        wait_done();
        release_out(stall);
    endtask

    initial begin
        #12;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_sum", sum, '0);
        chk("rst_carry", W'(carry_out), W'(0));
        chk("rst_ovf", W'(overflow), W'(0));
        rst_n = 1'b1;

        // Directed corner cases
        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0);
        run_op(64'h0, 64'h1, 1'b1, 0);
        run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 0);

        // Backpressure with a pending request held on the input
        issue(64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b0);
        wait_done();
        in_valid = 1'b1;
        op1 = 64'h0000_0000_0000_0005;
        op2 = 64'h0000_0000_0000_0007;
        sub = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_sum", sum, exp_sum);
            chk("bp_in_ready", W'(in_ready), W'(0));
            chk("bp_valid", W'(out_valid), W'(1));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
`ifdef MPADD_OPCOUNT_EN
        exp_count++;
`endif
        @(negedge clk);
        chk("bp_accept_ready", W'(in_ready), W'(1));
        chk("bp_accept_valid", W'(out_valid), W'(0));
        model(op1, op2, sub);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done();
        release_out(0);

        // Asynchronous reset during the second RUN cycle
        issue(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", W'(in_ready), W'(1));
        chk("arst_out_valid", W'(out_valid), W'(0));
        chk("arst_sum", sum, '0);
        chk("arst_carry", W'(carry_out), W'(0));
        chk("arst_ovf", W'(overflow), W'(0));
`ifdef MPADD_OPCOUNT_EN
        exp_count = 0;
        chk("arst_op_count", W'(op_count), W'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("aborted_no_valid", W'(out_valid), W'(0));
        end
        run_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 0);

        // Randomized operations with random backpressure
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] a, b;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = ~a;
                1: a[W-1] = b[W-1];
                default: ;
            endcase
            run_op(a, b, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit, errors so far %0d", n_errors);
        $fatal(1);
    end
endmodule
